ym2149_wb_sequencer: RTL and testbench

- Pipelined Wishbone master that drives the YM2149 PSG register-write slave.
- Accepts a stream of PSG commands through a valid/ready port into an internal FIFO. Each command is either a register write or a "wait N frames" entry.
- Issues one single-beat Wishbone write per register command and paces frames from an internal frame tick (e.g. 50 Hz VBL).
- Sits between a CPU/DMA music-data source and the PSG slave, so tunes play without CPU timing involvement.

---
 rtl/ym2149_wb_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ym2149_wb_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ym2149_wb_sequencer.sv
// YM2149 PSG Wishbone write sequencer: command FIFO, frame-paced waits, one outstanding write.
// Optional bus watchdog and timeout_flag_o port: define YM2149_WB_SEQ_TIMEOUT_EN.
module ym2149_wb_sequencer #(
  parameter int unsigned CLK_IN_HZ  = 100000000,
  parameter int unsigned FRAME_HZ   = 50,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wait_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [7:0]  cmd_data_i,
  input  logic        enable_i,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_w_o,
  input  logic [31:0] wb_dat_r_i,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_stall_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_we_o,
  input  logic        wb_err_i,
  output logic        busy_o,
  output logic        err_flag_o
`ifdef YM2149_WB_SEQ_TIMEOUT_EN
  ,
  output logic        timeout_flag_o
`endif
);
  localparam int unsigned Period = CLK_IN_HZ / FRAME_HZ;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StAckw, StWait} state_e;

  // Entry layout: {wait, addr[7:0], data[7:0]}
  logic [16:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop;
  logic [16:0]     head;

  logic [31:0] frame_cnt_q;
  logic        tick;

  state_e      state_q;
  logic        cyc_q, stb_q, err_q;
  logic [7:0]  adr_q, dat_q, wait_cnt_q;
  logic        done;

  logic unused_dat_r;
  assign unused_dat_r = ^wb_dat_r_i;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign push  = cmd_valid_i && !full;
  assign pop   = (state_q == StIdle) && enable_i && !empty;
  assign head  = mem_q[rd_ptr_q];
  assign tick  = (frame_cnt_q == Period - 1);
  assign done  = wb_ack_i || wb_err_i;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_wait_i, cmd_addr_i, cmd_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || tick) frame_cnt_q <= '0;
    else               frame_cnt_q <= frame_cnt_q + 32'd1;
  end

`ifdef YM2149_WB_SEQ_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        tmo_q;
  assign timeout_flag_o = tmo_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`ifdef YM2149_WB_SEQ_TIMEOUT_EN
      wdog_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            if (!head[16]) begin
              adr_q   <= head[15:8];
              dat_q   <= head[7:0];
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              state_q <= StReq;
`ifdef YM2149_WB_SEQ_TIMEOUT_EN
              wdog_q  <= '0;
`endif
            end else if (head[7:0] != 8'd0) begin
              wait_cnt_q <= head[7:0];
              state_q    <= StWait;
            end
          end
        end
        StReq: begin
          // ack/err while stalled still completes the transfer
          if (done) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= StIdle;
            if (wb_err_i) err_q <= 1'b1;
          end else if (!wb_stall_i) begin
            stb_q   <= 1'b0;
            state_q <= StAckw;
          end
        end
        StAckw: begin
          if (done) begin
            cyc_q   <= 1'b0;
            state_q <= StIdle;
            if (wb_err_i) err_q <= 1'b1;
          end
        end
        StWait: begin
          if (tick) begin
            if (wait_cnt_q == 8'd1) state_q <= StIdle;
            wait_cnt_q <= wait_cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef YM2149_WB_SEQ_TIMEOUT_EN
      if ((state_q == StReq || state_q == StAckw) && !done) begin
        if (wdog_q == 16'hFFFE) begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          state_q <= StIdle;
          err_q   <= 1'b1;
          tmo_q   <= 1'b1;
        end else begin
          wdog_q <= wdog_q + 16'd1;
        end
      end
`endif
    end
  end

  assign cmd_ready_o = !full;
  assign wb_adr_o    = adr_q;
  assign wb_dat_w_o  = {24'b0, dat_q};
  assign wb_sel_o    = 4'b0001;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = cyc_q;
  assign busy_o      = !empty || (state_q != StIdle);
  assign err_flag_o  = err_q;

endmodule

// File: tb/tb_ym2149_wb_sequencer.sv
// Directed bench for ym2149_wb_sequencer with a PSG-style slave model (P = 10 cycles).
module tb_ym2149_wb_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wait = 1'b0, enable = 1'b1;
  logic [7:0]  cmd_addr = '0, cmd_data = '0, wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_stall, wb_cyc, wb_stb, wb_ack, wb_we, wb_err, busy, err_flag;

  always #5 clk = ~clk;

  ym2149_wb_sequencer #(
    .CLK_IN_HZ (1000),
    .FRAME_HZ  (100),
    .FIFO_DEPTH(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_wait_i (cmd_wait),
    .cmd_addr_i (cmd_addr),
    .cmd_data_i (cmd_data),
    .enable_i   (enable),
    .wb_adr_o   (wb_adr),
    .wb_dat_w_o (wb_dat_w),
    .wb_dat_r_i (32'hDEAD_BEEF),
    .wb_sel_o   (wb_sel),
    .wb_stall_i (wb_stall),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_ack_i   (wb_ack),
    .wb_we_o    (wb_we),
    .wb_err_i   (wb_err),
    .busy_o     (busy),
    .err_flag_o (err_flag)
  );

  // Cycle counter and reference frame counter (tick when at 9)
  int unsigned cyc_n = 0;
  int          tcnt = 0;
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    tcnt  <= rst ? 0 : ((tcnt == 9) ? 0 : tcnt + 1);
  end

  // Slave: mode 0 = acks one cycle after stb, stall = cyc && !ack; mode 1 = never stalls or acks
  logic resp_q = 1'b0;
  int   nresp = 0, err_idx = -1, mode = 0;
  always @(posedge clk) begin
    if (rst) resp_q <= 1'b0;
    else begin
      resp_q <= (mode == 0) && wb_cyc && wb_stb && !resp_q;
      if (resp_q) nresp <= nresp + 1;
    end
  end
  assign wb_ack   = resp_q && (nresp != err_idx);
  assign wb_err   = resp_q && (nresp == err_idx);
  assign wb_stall = (mode == 0) && wb_cyc && !resp_q;

  typedef struct {
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int unsigned cyc;
  } acc_t;
  acc_t        acc_q[$];
  int unsigned rise_q[$];
  int unsigned tick_q[$];
  logic        stb_prev = 1'b0;

  always @(negedge clk) begin
    if (wb_cyc && wb_stb && !wb_stall) acc_q.push_back('{wb_adr, wb_dat_w, wb_sel, wb_we, cyc_n});
    if (wb_stb && !stb_prev) rise_q.push_back(cyc_n);
    stb_prev <= wb_stb;
    if (!rst && tcnt == 9) tick_q.push_back(cyc_n);
  end

  int n_vec = 0, n_miss = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    int guard = 0;
    cmd_valid = 1'b1; cmd_wait = w; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && guard < 200) begin step(); guard++; end
    if (guard >= 200) check("push_timeout", 32'd0, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 2000) begin step(); guard++; end
    if (guard >= 2000) check("idle_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    int n0, r0, idx, guard, k, t, seen;
    logic saw_full, rdy;
    int unsigned c;

    // Reset
    step(); step();
    check("rst_cyc", wb_cyc, 0);
    check("rst_stb", wb_stb, 0);
    check("rst_we", wb_we, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_dat", wb_dat_w, 0);
    check("rst_err", err_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    step();

    // Single write 0x07 <- 0x38
    n0 = acc_q.size();
    push(1'b0, 8'h07, 8'h38);
    guard = 0;
    while (acc_q.size() == n0 && guard < 20) begin step(); guard++; end
    check("w1_seen", acc_q.size() > n0, 1);
    check("w1_ack_same_cycle", wb_ack, 1);
    if (acc_q.size() > n0) begin
      check("w1_adr", acc_q[n0].adr, 32'h07);
      check("w1_dat", acc_q[n0].dat, 32'h38);
      check("w1_sel", acc_q[n0].sel, 32'h1);
      check("w1_we", acc_q[n0].we, 1);
    end
    step();
    check("w1_cyc_dropped", wb_cyc, 0);
    check("w1_busy_clear", busy, 0);
    step(); step();
    check("w1_one_accept", acc_q.size() - n0, 1);

    // 20 writes, paused first so the FIFO fills
    n0 = acc_q.size(); idx = 0; saw_full = 1'b0; guard = 0;
    enable = 1'b0;
    while (idx < 20 && guard < 400) begin
      cmd_valid = 1'b1; cmd_wait = 1'b0;
      cmd_addr = 8'(idx); cmd_data = 8'hA0 + 8'(idx);
      rdy = cmd_ready;
      if (!rdy && !saw_full) begin
        saw_full = 1'b1;
        check("fill_count", idx, 16);
        check("paused_no_bus", acc_q.size() - n0, 0);
        enable = 1'b1;
      end
      step(); guard++;
      if (rdy) idx++;
    end
    cmd_valid = 1'b0;
    enable = 1'b1;
    wait_idle();
    check("fill_ready_low", saw_full, 1);
    check("burst_count", acc_q.size() - n0, 20);
    for (int i = 0; i < 20; i++) begin
      if (n0 + i < acc_q.size()) begin
        check($sformatf("burst_adr%0d", i), acc_q[n0+i].adr, i);
        check($sformatf("burst_dat%0d", i), acc_q[n0+i].dat, 32'hA0 + i);
      end
    end

    // Write A, wait 3 frames, write B
    n0 = acc_q.size(); r0 = rise_q.size();
    push(1'b0, 8'h01, 8'h11);
    push(1'b1, 8'h00, 8'd3);
    push(1'b0, 8'h02, 8'h22);
    wait_idle();
    check("wait_writes", acc_q.size() - n0, 2);
    if (acc_q.size() >= n0 + 2 && rise_q.size() >= r0 + 2) begin
      k = int'(acc_q[n0].cyc);
      t = -1; seen = 0;
      foreach (tick_q[i]) begin
        if (int'(tick_q[i]) >= k + 2 && seen < 3) begin
          seen++;
          if (seen == 3) t = int'(tick_q[i]);
        end
      end
      check("wait_b_rise", rise_q[r0+1], t + 2);
      check("wait_b_adr", acc_q[n0+1].adr, 32'h02);
    end

    // Wait 0 followed by a write: no tick dependency
    n0 = acc_q.size(); r0 = rise_q.size();
    c = cyc_n;
    push(1'b1, 8'h00, 8'd0);
    push(1'b0, 8'h03, 8'h33);
    wait_idle();
    check("wait0_count", acc_q.size() - n0, 1);
    if (rise_q.size() > r0) check("wait0_rise", rise_q[r0], c + 3);
    if (acc_q.size() > n0) check("wait0_dat", acc_q[n0].dat, 32'h33);

    // Error on the 2nd of 3 writes
    n0 = acc_q.size();
    check("err_before", err_flag, 0);
    err_idx = nresp + 1;
    push(1'b0, 8'h04, 8'h41);
    push(1'b0, 8'h05, 8'h52);
    push(1'b0, 8'h06, 8'h63);
    wait_idle();
    check("err_set", err_flag, 1);
    check("err_count", acc_q.size() - n0, 3);
    if (acc_q.size() >= n0 + 3) check("err_third_adr", acc_q[n0+2].adr, 32'h06);
    err_idx = -1;
    repeat (5) step();
    check("err_sticky", err_flag, 1);

    // Reset while waiting for ack
    mode = 1;
    push(1'b0, 8'h08, 8'h80);
    push(1'b0, 8'h09, 8'h90);
    guard = 0;
    while (!(wb_cyc && !wb_stb) && guard < 20) begin step(); guard++; end
    check("ackw_reached", wb_cyc && !wb_stb, 1);
    rst = 1'b1;
    step();
    check("rst2_cyc", wb_cyc, 0);
    check("rst2_stb", wb_stb, 0);
    check("rst2_busy", busy, 0);
    check("rst2_ready", cmd_ready, 1);
    check("rst2_err", err_flag, 0);
    rst = 1'b0; mode = 0;
    n0 = acc_q.size();
    repeat (4) step();
    check("rst2_fifo_empty", busy, 0);
    check("rst2_no_bus", acc_q.size() - n0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
